// File: rtl/spec_register_alias_table.sv
// Speculative rename map table (front-end RAT) with flush recovery
// from the committed architectural map.
//
// Ports:
//   clk, a_rst           clock, async active-high reset
//   flush_i              flush pulse, starts recovery
//   arch_rat_i           committed map, 32 x PW (entry k at [k*PW +: PW])
//   valid_i, ready_o     rename group handshake (fire = |valid_i & ready_o)
//   src0_i, src1_i       logical sources, DW x 5
//   dest_valid_i, dest_i logical destination per slot
//   preg_i               newly allocated pregs, DW x PW
//   valid_o              registered slot valid
//   psrc0_o, psrc1_o     renamed sources
//   ppdst_o              previous mapping of each dest
//   recovering_o         high while restoring from arch_rat_i
//
// Build option: SRAT_FAST_RECOVER_EN restores all 32 entries in one
// cycle; otherwise RECOVER_WIDTH entries are copied per cycle.

`ifndef DECODE_WIDTH
`define DECODE_WIDTH 2
`endif

module spec_register_alias_table #(
   parameter int PHY_REG_NUM   = 64,
   parameter int RECOVER_WIDTH = 8,
   localparam int PW = $clog2(PHY_REG_NUM),
   localparam int DW = `DECODE_WIDTH
) (
   input  logic             clk,
   input  logic             a_rst,
   input  logic             flush_i,
   input  logic [32*PW-1:0] arch_rat_i,
   input  logic [DW-1:0]    valid_i,
   output logic             ready_o,
   input  logic [DW*5-1:0]  src0_i,
   input  logic [DW*5-1:0]  src1_i,
   input  logic [DW-1:0]    dest_valid_i,
   input  logic [DW*5-1:0]  dest_i,
   input  logic [DW*PW-1:0] preg_i,
   output logic [DW-1:0]    valid_o,
   output logic [DW*PW-1:0] psrc0_o,
   output logic [DW*PW-1:0] psrc1_o,
   output logic [DW*PW-1:0] ppdst_o,
   output logic             recovering_o
);

   typedef enum logic {
      S_IDLE,
      S_RECOVER
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [PW-1:0] rat_q [32];

   logic          fire;
   logic          rec_done;
   logic [31:0]   copy_sel;
   logic [DW-1:0] wr_en;

   logic [DW*PW-1:0] psrc0_d;
   logic [DW*PW-1:0] psrc1_d;
   logic [DW*PW-1:0] ppdst_d;

   // A flush always wins, so a group presented with it is dropped.
   assign fire = ready_o & (|valid_i) & ~flush_i;

`ifdef SRAT_FAST_RECOVER_EN

   assign rec_done = 1'b1;

   always_comb begin
      copy_sel = '0;
      if (state_q == S_RECOVER && !flush_i) begin
         copy_sel = '1;
      end
   end

`else

   localparam int NSTEP = 32 / RECOVER_WIDTH;
   localparam int IW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

   logic [IW-1:0] idx_q;

   assign rec_done = (idx_q == IW'(NSTEP - 1));

   // A flush mid-walk restarts the walk from chunk 0.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         idx_q <= '0;
      end else if (flush_i || state_q == S_IDLE) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_q + 1'b1;
      end
   end

   always_comb begin
      copy_sel = '0;
      if (state_q == S_RECOVER && !flush_i) begin
         for (int k = 0; k < 32; k++) begin
            copy_sel[k] = ((k / RECOVER_WIDTH) == int'(idx_q));
         end
      end
   end

`endif

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ready_o      = 1'b0;
      recovering_o = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            ready_o = 1'b1;
            if (flush_i) begin
               state_d = S_RECOVER;
            end
         end
         S_RECOVER: begin
            recovering_o = 1'b1;
            if (flush_i) begin
               state_d = S_RECOVER;
            end else if (rec_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // r0 is never written from rename.
   always_comb begin
      for (int i = 0; i < DW; i++) begin
         wr_en[i] = valid_i[i] & dest_valid_i[i] &
                    (dest_i[i*5 +: 5] != 5'd0);
      end
   end

   // Lookups see the pre-update table, overridden by the youngest
   // older slot in the same group that writes the register.
   always_comb begin
      for (int i = 0; i < DW; i++) begin
         psrc0_d[i*PW +: PW] = rat_q[src0_i[i*5 +: 5]];
         psrc1_d[i*PW +: PW] = rat_q[src1_i[i*5 +: 5]];
         ppdst_d[i*PW +: PW] = rat_q[dest_i[i*5 +: 5]];
         for (int j = 0; j < i; j++) begin
            if (wr_en[j] &&
                dest_i[j*5 +: 5] == src0_i[i*5 +: 5]) begin
               psrc0_d[i*PW +: PW] = preg_i[j*PW +: PW];
            end
            if (wr_en[j] &&
                dest_i[j*5 +: 5] == src1_i[i*5 +: 5]) begin
               psrc1_d[i*PW +: PW] = preg_i[j*PW +: PW];
            end
            if (wr_en[j] &&
                dest_i[j*5 +: 5] == dest_i[i*5 +: 5]) begin
               ppdst_d[i*PW +: PW] = preg_i[j*PW +: PW];
            end
         end
      end
   end

   // Later slots are assigned last, so the youngest writer wins on WAW.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         for (int k = 0; k < 32; k++) begin
            rat_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < 32; k++) begin
            if (copy_sel[k]) begin
               rat_q[k] <= arch_rat_i[k*PW +: PW];
            end else if (fire) begin
               for (int i = 0; i < DW; i++) begin
                  if (wr_en[i] && dest_i[i*5 +: 5] == 5'(k)) begin
                     rat_q[k] <= preg_i[i*PW +: PW];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         valid_o <= '0;
         psrc0_o <= '0;
         psrc1_o <= '0;
         ppdst_o <= '0;
      end else begin
         valid_o <= fire ? valid_i : '0;
         if (fire) begin
            psrc0_o <= psrc0_d;
            psrc1_o <= psrc1_d;
            ppdst_o <= ppdst_d;
         end
      end
   end

endmodule
